// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32 control FSM: sequences FETCH/DECODE/EXEC/MEM/WB with memory
// ready handshakes, illegal-opcode and memory-timeout traps, and a retire counter.
module multicycle_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter bit TRAP_EN     = 1'b1,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       opcode,
   input  logic             imem_ready,
   input  logic             dmem_ready,
   output logic             imem_req,
   output logic             dmem_req,
   output logic             ir_write,
   output logic             pc_write,
   output logic             branch,
   output logic             mem_read,
   output logic             mem_write,
   output logic             mem2reg,
   output logic             alu_src,
   output logic [1:0]       aluop,
   output logic             reg_write,
   output logic             illegal,
   output logic             bus_err,
   output logic [CNT_W-1:0] instret
);

   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;
   typedef enum logic [2:0] {C_NONE, C_R, C_LOAD, C_IMM, C_STORE, C_BRANCH, C_ILLEGAL} class_t;

   localparam int TO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

   state_t           state_reg, state_next;
   class_t           class_reg, class_next;
   class_t           dec_class;
   logic [TO_W-1:0]  cnt_reg, cnt_next;
   logic [CNT_W-1:0] instret_reg;
   logic             illegal_reg, bus_err_reg;
   logic             waiting, timeout, trap_illegal;
   logic [1:0]       exec_aluop;
   logic             exec_src;

   always_comb begin
      case (opcode)
         7'b0110011: dec_class = C_R;
         7'b0000011: dec_class = C_LOAD;
         7'b0010011: dec_class = C_IMM;
         7'b0100011: dec_class = C_STORE;
         7'b1100011: dec_class = C_BRANCH;
         default:    dec_class = C_ILLEGAL;
      endcase
   end

   // A ready arriving in the last allowed cycle wins over the timeout.
   assign waiting      = ((state_reg == S_FETCH) && !imem_ready) ||
                         ((state_reg == S_MEM) && !dmem_ready);
   assign timeout      = (MEM_TIMEOUT != 0) && waiting && (cnt_reg == TO_LAST);
   assign trap_illegal = (state_reg == S_DECODE) && (dec_class == C_ILLEGAL) && TRAP_EN;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= S_FETCH;
         class_reg   <= C_NONE;
         cnt_reg     <= '0;
         instret_reg <= '0;
         illegal_reg <= 1'b0;
         bus_err_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         class_reg <= class_next;
         cnt_reg   <= cnt_next;
         if (pc_write)
            instret_reg <= instret_reg + CNT_W'(1);
         if (trap_illegal)
            illegal_reg <= 1'b1;
         if (timeout)
            bus_err_reg <= 1'b1;
      end
   end

   always_comb begin
      state_next = state_reg;
      class_next = class_reg;
      case (state_reg)
         S_FETCH: begin
            if (imem_ready)   state_next = S_DECODE;
            else if (timeout) state_next = S_TRAP;
         end
         S_DECODE: begin
            class_next = dec_class;
            if (dec_class == C_ILLEGAL) state_next = TRAP_EN ? S_TRAP : S_FETCH;
            else                        state_next = S_EXEC;
         end
         S_EXEC: begin
            case (class_reg)
               C_R, C_IMM:      state_next = S_WB;
               C_LOAD, C_STORE: state_next = S_MEM;
               default:         state_next = S_FETCH;
            endcase
         end
         S_MEM: begin
            if (dmem_ready)   state_next = (class_reg == C_LOAD) ? S_WB : S_FETCH;
            else if (timeout) state_next = S_TRAP;
         end
         S_WB:    state_next = S_FETCH;
         S_TRAP:  state_next = S_TRAP;
         default: state_next = S_FETCH;
      endcase
      // Every state change lands in a fresh wait window.
      if (state_next != state_reg) cnt_next = '0;
      else if (waiting)            cnt_next = cnt_reg + TO_W'(1);
      else                         cnt_next = cnt_reg;
   end

   always_comb begin
      exec_aluop = 2'b00;
      exec_src   = 1'b0;
      case (class_reg)
         C_R:             exec_aluop = 2'b10;
         C_IMM:           begin exec_aluop = 2'b11; exec_src = 1'b1; end
         C_LOAD, C_STORE: exec_src = 1'b1;
         C_BRANCH:        exec_aluop = 2'b01;
         default:         ;
      endcase
   end

   always_comb begin
      imem_req  = 1'b0;
      dmem_req  = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      branch    = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem2reg   = 1'b0;
      alu_src   = 1'b0;
      aluop     = 2'b00;
      reg_write = 1'b0;
      illegal   = illegal_reg && !rst;
      bus_err   = bus_err_reg && !rst;
      instret   = rst ? '0 : instret_reg;
      if (!rst) begin
         case (state_reg)
            S_FETCH: begin
               imem_req = 1'b1;
               ir_write = imem_ready;
            end
            S_DECODE: pc_write = (dec_class == C_ILLEGAL) && !TRAP_EN;
            S_EXEC: begin
               aluop   = exec_aluop;
               alu_src = exec_src;
               if (class_reg == C_BRANCH) begin
                  branch   = 1'b1;
                  pc_write = 1'b1;
               end
            end
            S_MEM: begin
               dmem_req  = 1'b1;
               alu_src   = 1'b1;
               mem_read  = (class_reg == C_LOAD);
               mem_write = (class_reg == C_STORE);
               pc_write  = dmem_ready && (class_reg == C_STORE);
            end
            S_WB: begin
               reg_write = 1'b1;
               pc_write  = 1'b1;
               mem2reg   = (class_reg == C_LOAD);
               aluop     = exec_aluop;
               alu_src   = exec_src;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: instructions expand into expected per-cycle output traces,
// checked on two instances (trap/timeout=8 and NOP-retire/timeout=16), both CNT_W=4.
module tb_multicycle_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a, rst_b, imem_ready, dmem_ready;
   logic [6:0] opcode;

   logic imem_req_a, dmem_req_a, ir_write_a, pc_write_a, branch_a, mem_read_a, mem_write_a;
   logic mem2reg_a, alu_src_a, reg_write_a, illegal_a, bus_err_a;
   logic [1:0] aluop_a;
   logic [3:0] instret_a;
   logic imem_req_b, dmem_req_b, ir_write_b, pc_write_b, branch_b, mem_read_b, mem_write_b;
   logic mem2reg_b, alu_src_b, reg_write_b, illegal_b, bus_err_b;
   logic [1:0] aluop_b;
   logic [3:0] instret_b;

   multicycle_ctrl #(.MEM_TIMEOUT(8), .TRAP_EN(1'b1), .CNT_W(4)) dut_a (
      .clk(clk), .rst(rst_a), .opcode(opcode), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
      .imem_req(imem_req_a), .dmem_req(dmem_req_a), .ir_write(ir_write_a), .pc_write(pc_write_a),
      .branch(branch_a), .mem_read(mem_read_a), .mem_write(mem_write_a), .mem2reg(mem2reg_a),
      .alu_src(alu_src_a), .aluop(aluop_a), .reg_write(reg_write_a), .illegal(illegal_a),
      .bus_err(bus_err_a), .instret(instret_a));

   multicycle_ctrl #(.MEM_TIMEOUT(16), .TRAP_EN(1'b0), .CNT_W(4)) dut_b (
      .clk(clk), .rst(rst_b), .opcode(opcode), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
      .imem_req(imem_req_b), .dmem_req(dmem_req_b), .ir_write(ir_write_b), .pc_write(pc_write_b),
      .branch(branch_b), .mem_read(mem_read_b), .mem_write(mem_write_b), .mem2reg(mem2reg_b),
      .alu_src(alu_src_b), .aluop(aluop_b), .reg_write(reg_write_b), .illegal(illegal_b),
      .bus_err(bus_err_b), .instret(instret_b));

   // {ctl[11:0], illegal, bus_err, instret[3:0]}
   logic [17:0] out_a, out_b;
   assign out_a = {imem_req_a, dmem_req_a, ir_write_a, pc_write_a, branch_a, mem_read_a,
                   mem_write_a, mem2reg_a, alu_src_a, aluop_a, reg_write_a,
                   illegal_a, bus_err_a, instret_a};
   assign out_b = {imem_req_b, dmem_req_b, ir_write_b, pc_write_b, branch_b, mem_read_b,
                   mem_write_b, mem2reg_b, alu_src_b, aluop_b, reg_write_b,
                   illegal_b, bus_err_b, instret_b};

   localparam logic [11:0] C_IMEM = 12'h800, C_DREQ = 12'h400, C_IRW = 12'h200,
                           C_PCW = 12'h100, C_BR = 12'h080, C_MR = 12'h040, C_MW = 12'h020,
                           C_M2R = 12'h010, C_SRC = 12'h008, C_ALU01 = 12'h002,
                           C_ALU10 = 12'h004, C_ALU11 = 12'h006, C_RW = 12'h001;
   localparam logic [6:0] OP_R = 7'b0110011, OP_LD = 7'b0000011, OP_IMM = 7'b0010011,
                          OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_BAD = 7'b1111111;

   typedef struct {
      bit          rst;
      bit          ir;
      bit          dr;
      logic [6:0]  op;
      logic [17:0] exp;
   } cyc_t;

   cyc_t  q[$];
   int    checks = 0, errors = 0;
   string tag;
   int    sel, m_to, m_instret;
   bit    m_trap_en, m_ill, m_berr;
   int    obs_pcw, obs_rw, obs_mr, obs_mw, obs_br, obs_m2r, obs_berr, obs_wrap;
   logic [17:0] last_out;

   task automatic push(input bit r, input bit ir, input bit dr, input logic [6:0] op,
                       input logic [11:0] ctl);
      cyc_t c;
      c.rst = r;
      c.ir  = ir;
      c.dr  = dr;
      c.op  = op;
      c.exp = r ? 18'h0 : {ctl, m_ill, m_berr, 4'(m_instret)};
      q.push_back(c);
      if (!r && ((ctl & C_PCW) != 12'h0)) m_instret++;
   endtask

   // Readies are asserted during reset and trap cycles: neither may react to them.
   task automatic reset_cycles(input int n);
      for (int i = 0; i < n; i++) push(1'b1, 1'b1, 1'b1, 7'h0, 12'h0);
      m_instret = 0;
      m_ill     = 1'b0;
      m_berr    = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) push(1'b0, 1'b1, 1'b1, 7'h0, 12'h0);
   endtask

   // One instruction: iw/dw = wait cycles before imem/dmem ready; abort >= 0 stops
   // the data access after that many wait cycles (caller then asserts reset).
   task automatic instr(input logic [6:0] op, input int iw, input int dw, input int abort);
      int          cls;
      logic [11:0] ex, mc;
      case (op)
         OP_R:    cls = 0;
         OP_LD:   cls = 1;
         OP_IMM:  cls = 2;
         OP_ST:   cls = 3;
         OP_BR:   cls = 4;
         default: cls = 5;
      endcase
      for (int k = 0; k < iw; k++) begin
         push(1'b0, 1'b0, 1'b0, op, C_IMEM);
         if (m_to != 0 && k == m_to - 1) begin m_berr = 1'b1; return; end
      end
      push(1'b0, 1'b1, 1'b0, op, C_IMEM | C_IRW);
      if (cls == 5) begin
         if (m_trap_en) begin push(1'b0, 1'b0, 1'b0, op, 12'h0); m_ill = 1'b1; end
         else push(1'b0, 1'b0, 1'b0, op, C_PCW);
         return;
      end
      push(1'b0, 1'b0, 1'b0, op, 12'h0);
      ex = (cls == 0) ? C_ALU10 : (cls == 2) ? (C_ALU11 | C_SRC) :
           (cls == 4) ? (C_ALU01 | C_BR | C_PCW) : C_SRC;
      push(1'b0, 1'b0, 1'b0, op, ex);
      if (cls == 4) return;
      if (cls == 1 || cls == 3) begin
         mc = C_DREQ | C_SRC | ((cls == 1) ? C_MR : C_MW);
         for (int k = 0; k < dw; k++) begin
            if (abort >= 0 && k == abort) return;
            push(1'b0, 1'b0, 1'b0, op, mc);
            if (m_to != 0 && k == m_to - 1) begin m_berr = 1'b1; return; end
         end
         push(1'b0, 1'b0, 1'b1, op, (cls == 3) ? (mc | C_PCW) : mc);
         if (cls == 3) return;
      end
      push(1'b0, 1'b0, 1'b0, op, ex | C_RW | C_PCW | ((cls == 1) ? C_M2R : 12'h0));
   endtask

   task automatic run();
      cyc_t        c;
      logic [17:0] got, oth;
      logic [3:0]  prev_ins;
      int          n;
      n = 0;
      prev_ins = 4'h0;
      obs_pcw = 0; obs_rw = 0; obs_mr = 0; obs_mw = 0;
      obs_br = 0; obs_m2r = 0; obs_berr = 0; obs_wrap = 0;
      while (q.size() > 0) begin
         c = q.pop_front();
         @(posedge clk);
         #1;
         rst_a      = (sel == 0) ? c.rst : 1'b1;
         rst_b      = (sel == 1) ? c.rst : 1'b1;
         imem_ready = c.ir;
         dmem_ready = c.dr;
         opcode     = c.op;
         @(negedge clk);
         got = (sel == 0) ? out_a : out_b;
         oth = (sel == 0) ? out_b : out_a;
         checks++;
         if (got !== c.exp) begin
            errors++;
            $display("FAIL %s cyc %0d: outputs %h, required %h", tag, n, got, c.exp);
         end
         checks++;
         if (oth !== 18'h0) begin
            errors++;
            $display("FAIL %s cyc %0d reset_dut: outputs %h, required 0", tag, n, oth);
         end
         obs_pcw  += int'(got[14]);
         obs_br   += int'(got[13]);
         obs_mr   += int'(got[12]);
         obs_mw   += int'(got[11]);
         obs_m2r  += int'(got[10]);
         obs_rw   += int'(got[6]);
         obs_berr += int'(got[4]);
         if (n > 0 && prev_ins == 4'd15 && got[3:0] == 4'd0) obs_wrap = 1;
         prev_ins = got[3:0];
         last_out = got;
         n++;
      end
      $display("seg %s: %0d cycles on dut_%s", tag, n, (sel == 0) ? "a" : "b");
   endtask

   task automatic pin(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s %s: got %0d (0x%0h), required %0d (0x%0h)", tag, name, got, got, exp, exp);
      end
   endtask

   initial begin
      rst_a = 1'b1; rst_b = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0; opcode = 7'h0;
      sel = 0; m_to = 8; m_trap_en = 1'b1;
      m_instret = 0; m_ill = 1'b0; m_berr = 1'b0;
      last_out = 18'h0;

      tag = "reset";        reset_cycles(2); run();
      tag = "r_type";       instr(OP_R, 0, 0, -1); pin("len", q.size(), 4); run();
      pin("pcw", obs_pcw, 1); pin("rw", obs_rw, 1);
      tag = "load_wait3";   instr(OP_LD, 0, 3, -1); pin("len", q.size(), 8); run();
      pin("mr", obs_mr, 4); pin("m2r", obs_m2r, 1); pin("rw", obs_rw, 1);
      tag = "store_branch"; instr(OP_ST, 0, 0, -1); instr(OP_BR, 0, 0, -1);
      pin("len", q.size(), 7); run();
      pin("mw", obs_mw, 1); pin("rw", obs_rw, 0); pin("br", obs_br, 1); pin("pcw", obs_pcw, 2);
      pin("model_instret", m_instret, 4);
      tag = "illegal_trap"; instr(OP_BAD, 0, 0, -1); idle(3); run();
      pin("last", int'(last_out), 'h24);
      tag = "timeout_load"; reset_cycles(1); instr(OP_LD, 0, 20, -1); idle(2);
      pin("len", q.size(), 14); run();
      pin("mr", obs_mr, 8); pin("last", int'(last_out), 'h10);
      tag = "ready_on_8th"; reset_cycles(1); instr(OP_LD, 0, 7, -1);
      pin("len", q.size(), 13); run();
      pin("berr", obs_berr, 0); pin("pcw", obs_pcw, 1); pin("mr", obs_mr, 8);
      tag = "fetch_timeout"; reset_cycles(1); instr(OP_R, 12, 0, -1); idle(2); run();
      pin("last", int'(last_out), 'h10);
      tag = "rst_in_mem";   reset_cycles(1); instr(OP_R, 0, 0, -1); instr(OP_LD, 0, 10, 2);
      reset_cycles(1); instr(OP_IMM, 0, 0, -1); run();
      pin("pcw", obs_pcw, 2); pin("last", int'(last_out), 'h43C0);
      tag = "wrap";         reset_cycles(1);
      for (int i = 0; i < 17; i++) instr(OP_BR, 0, 0, -1);
      run();
      pin("wrap", obs_wrap, 1); pin("br", obs_br, 17);

      sel = 1; m_to = 16; m_trap_en = 1'b0;
      tag = "nop_retire";   reset_cycles(2); instr(OP_BAD, 0, 0, -1);
      pin("len", q.size(), 4); run();
      pin("pcw", obs_pcw, 1); pin("last", int'(last_out), 'h4000);
      tag = "b_load_wait10"; instr(OP_LD, 0, 10, -1); run();
      pin("berr", obs_berr, 0); pin("mr", obs_mr, 11);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
